// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer around a combinational 8-point FFT core: serial fill, settle, capture, serial drain.
// Build macro FFT8_FRAME_CTRL_PINGPONG_EN adds a second frame bank so filling overlaps processing.
module fft8_frame_ctrl #(
    parameter int unsigned DW     = 32,
    parameter int unsigned SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    output logic [8*DW-1:0] fft_x,
    input  logic [8*DW-1:0] fft_xr,
    input  logic [8*DW-1:0] fft_xi,
    output logic [DW-1:0]   out_re,
    output logic [DW-1:0]   out_im,
    output logic [2:0]      out_idx,
    output logic            out_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic [15:0]     frame_cnt
);
    typedef enum logic [1:0] {S_FILL, S_SETTLE, S_CAPTURE, S_DRAIN} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t        state_q;
    logic [2:0]    fill_cnt_q;
    logic [2:0]    idx_q;
    logic [3:0]    settle_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [15:0]   frame_cnt_q;
    logic [DW-1:0] res_re_q [8];
    logic [DW-1:0] res_im_q [8];
    logic          acc_in;
    logic          acc_out;

`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
    logic [DW-1:0] bank_q [2][8];
    logic          cur_q;
    logic          pend_q;
    logic          wr_bank;

    // In FILL the bank in flight is the one being filled; otherwise samples go to the idle bank.
    assign wr_bank = (state_q == S_FILL) ? cur_q : ~cur_q;
`else
    logic [DW-1:0] frame_q [8];
`endif

    assign acc_in  = in_valid & in_ready_q & ~flush;
    assign acc_out = out_valid_q & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= '0;
            idx_q       <= '0;
            settle_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_cnt_q <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                res_re_q[k] <= '0;
                res_im_q[k] <= '0;
`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
                bank_q[0][k] <= '0;
                bank_q[1][k] <= '0;
`else
                frame_q[k]   <= '0;
`endif
            end
`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
            cur_q  <= 1'b0;
            pend_q <= 1'b0;
`endif
        end else if (flush) begin
            state_q     <= S_FILL;
            fill_cnt_q  <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
            cur_q  <= 1'b0;
            pend_q <= 1'b0;
            for (int unsigned k = 0; k < 8; k++) begin
                bank_q[0][k] <= '0;
                bank_q[1][k] <= '0;
            end
`endif
        end else begin
            if (acc_in) begin
`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
                bank_q[wr_bank][fill_cnt_q] <= in_data;
                if (state_q != S_FILL && fill_cnt_q == 3'd7) begin
                    pend_q     <= 1'b1;
                    in_ready_q <= 1'b0;
                end
`else
                frame_q[fill_cnt_q] <= in_data;
`endif
                fill_cnt_q <= fill_cnt_q + 3'd1;
            end
            unique case (state_q)
                S_FILL: begin
                    in_ready_q <= 1'b1;
                    if (acc_in && fill_cnt_q == 3'd7) begin
                        state_q  <= S_SETTLE;
                        settle_q <= SETTLE_LOAD;
`ifndef FFT8_FRAME_CTRL_PINGPONG_EN
                        in_ready_q <= 1'b0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (settle_q == 4'd0) state_q <= S_CAPTURE;
                    else                  settle_q <= settle_q - 4'd1;
                end
                S_CAPTURE: begin
                    for (int unsigned k = 0; k < 8; k++) begin
                        res_re_q[k] <= fft_xr[k*DW +: DW];
                        res_im_q[k] <= fft_xi[k*DW +: DW];
                    end
                    idx_q       <= '0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (acc_out) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            out_valid_q <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            in_ready_q  <= 1'b1;
`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
                            // Swap banks; a complete idle bank goes straight to SETTLE, a partial one keeps filling.
                            cur_q  <= ~cur_q;
                            pend_q <= 1'b0;
                            if (pend_q || (acc_in && fill_cnt_q == 3'd7)) begin
                                state_q  <= S_SETTLE;
                                settle_q <= SETTLE_LOAD;
                            end else begin
                                state_q <= S_FILL;
                            end
`else
                            state_q <= S_FILL;
`endif
                        end
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    always_comb begin
        fft_x = '0;
        for (int unsigned k = 0; k < 8; k++) begin
`ifdef FFT8_FRAME_CTRL_PINGPONG_EN
            fft_x[k*DW +: DW] = bank_q[cur_q][k];
`else
            fft_x[k*DW +: DW] = frame_q[k];
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_re    = res_re_q[idx_q];
    assign out_im    = res_im_q[idx_q];
    assign out_idx   = idx_q;
    assign out_last  = out_valid_q & (idx_q == 3'd7);
    assign busy      = (state_q != S_FILL) | (fill_cnt_q != 3'd0);
    assign frame_cnt = frame_cnt_q;

endmodule
